// File: rtl/eth_tx_arbiter_if.sv
// Bundle between the packet sources, the arbiter and the eth_10g transmit input.
// master is the arbiter side; slave is the environment driving sources and the core's tready.
interface eth_tx_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int GW     = $clog2(NUM_SRC);

  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC*KEEP_W-1:0] s_axis_tkeep;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic [KEEP_W-1:0]         m_axis_tkeep;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic                      m_axis_tready;
  logic [GW-1:0]             grant_id;
  logic                      busy;
  logic [NUM_SRC*CNT_W-1:0]  pkt_cnt;

  modport master (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
           grant_id, busy, pkt_cnt
  );

  modport slave (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
           grant_id, busy, pkt_cnt
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the eth_10g tx stream through a
// main+skid register slice, so the core's tready never reaches a source combinationally.
module eth_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  eth_tx_arbiter_if.master bus
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int GW     = $clog2(NUM_SRC);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  state_t                         state_q;
  logic [GW-1:0]                  grant_q;
  beat_t                          main_q, skid_q;
  logic                           main_vld_q, skid_vld_q;
  logic [NUM_SRC-1:0][CNT_W-1:0]  cnt_q;

  logic [GW-1:0]      next_grant_d;
  logic [GW-1:0]      idx;
  logic               any_req;
  beat_t              in_beat;
  logic               in_vld;
  logic               accept;
  logic               drain;
  logic [NUM_SRC-1:0] s_rdy;

  // Walk downward so the nearest requester after grant_q is the last one written.
  always_comb begin
    next_grant_d = grant_q;
    any_req      = 1'b0;
    idx          = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = GW'((32'(grant_q) + 32'(k)) % NUM_SRC);
      if (bus.s_axis_tvalid[idx]) begin
        next_grant_d = idx;
        any_req      = 1'b1;
      end
    end
  end

  always_comb begin
    in_beat = '0;
    in_vld  = 1'b0;
    s_rdy   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        in_beat.data = bus.s_axis_tdata[i*DATA_W +: DATA_W];
        in_beat.keep = bus.s_axis_tkeep[i*KEEP_W +: KEEP_W];
        in_beat.last = bus.s_axis_tlast[i];
        in_vld       = bus.s_axis_tvalid[i];
        s_rdy[i]     = (state_q == LOCKED) && !skid_vld_q;
      end
    end
  end

  assign accept = (state_q == LOCKED) && in_vld && !skid_vld_q;
  assign drain  = !main_vld_q || bus.m_axis_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= GW'(NUM_SRC - 1);
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q <= next_grant_d;
          state_q <= LOCKED;
        end
        LOCKED: if (accept && in_beat.last) begin
          state_q        <= IDLE;
          cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase

      // skid is only ever occupied while main is stalled, so it always drains first.
      if (drain) begin
        if (skid_vld_q) begin
          main_q     <= skid_q;
          main_vld_q <= 1'b1;
          skid_vld_q <= 1'b0;
        end else begin
          main_vld_q <= accept;
          if (accept) main_q <= in_beat;
        end
      end else if (accept) begin
        skid_q     <= in_beat;
        skid_vld_q <= 1'b1;
      end
    end
  end

  assign bus.s_axis_tready = s_rdy;
  assign bus.m_axis_tdata  = main_q.data;
  assign bus.m_axis_tkeep  = main_q.keep;
  assign bus.m_axis_tlast  = main_q.last;
  assign bus.m_axis_tvalid = main_vld_q;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state_q == LOCKED);
  assign bus.pkt_cnt       = cnt_q;
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single 64-bit transmit AXI-Stream input of eth_10g (s00_axis_*) between NUM_SRC independent packet sources.
- Arbitration is round-robin at packet granularity. Once a source is granted, its packet is forwarded intact up to and including tlast.
- A registered skid stage feeds the core, so the core's tready never combinationally reaches a source.
- Per-source packet counters are provided for VIO/ILA monitoring. The block runs entirely in the s00_axis_aclk domain.

Parameters:
- NUM_SRC, 2: number of requesting sources (2..8).
- DATA_W, 64: tdata width; KEEP_W = DATA_W/8.
- CNT_W, 16: width of each per-source packet counter.

Ports:
- clk  in  1  tx clock, driven from eth_10g s00_axis_aclk.
- reset  in  1  asynchronous, active-high.
- s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i occupies [i*DATA_W +: DATA_W].
- s_axis_tkeep  in  NUM_SRC*KEEP_W  source byte enables.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last beat.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_W  to eth_10g s00_axis_tdata.
- m_axis_tkeep  out  KEEP_W  to core.
- m_axis_tvalid  out  1  to core.
- m_axis_tlast  out  1  to core.
- m_axis_tready  in  1  from eth_10g s00_axis_tready.
- grant_id  out  $clog2(NUM_SRC)  index of the current or last granted source.
- busy  out  1  high while in LOCKED state.
- pkt_cnt  out  NUM_SRC*CNT_W  packets accepted per source, wrapping.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, grant_id=NUM_SRC-1, so the first pass starts at source 0.
  - m_axis_tvalid=0, skid entry empty, all s_axis_tready=0, busy=0, pkt_cnt=0.
  - m_axis_tdata/tkeep/tlast are 0 under reset.
- FSM states IDLE and LOCKED:
  - IDLE: all s_axis_tready=0. If any s_axis_tvalid is set, grant_id <= first i with tvalid, searching (grant_id+1) mod NUM_SRC upward with wrap, and state <= LOCKED. If no tvalid, stay in IDLE with grant_id unchanged.
  - LOCKED: s_axis_tready[grant_id] = !skid_full; all other readies are 0. Source beats are accepted on tvalid&&tready.
  - LOCKED -> IDLE on the accepted beat that has tlast=1. On that same edge, pkt_cnt[grant_id] increments, wrapping at 2^CNT_W.
  - Every packet therefore costs exactly 1 arbitration cycle (IDLE) between grants. This bubble is acceptable because the core tolerates inter-packet gaps.
- Within a packet:
  - A source may deassert tvalid mid-packet; the grant is held and nothing is forwarded meanwhile.
  - Requests from non-granted sources never preempt the current packet.
- Output stage (2-entry register slice, main + skid):
  - Latency: an accepted beat appears on m_axis_* on the next clk edge if the main register is empty or draining.
  - If main is valid and m_axis_tready=0, an accepted beat goes to skid. skid_full stalls the upstream source.
  - When main drains (m_axis_tready=1) and skid holds data, skid moves to main on that edge.
  - Sustained throughput is 1 beat/cycle with continuous tvalid and tready. No beat is ever dropped or duplicated.
  - m_axis_tvalid and m_axis_tdata/tkeep/tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous events:
  - A tlast accept in LOCKED and a new request on any source: the new grant is decided in the following IDLE cycle.
  - Slice output drain and input accept in the same cycle are handled without a bubble.
- tkeep and tdata are passed through unmodified. The arbiter does not check tkeep contiguity.
- A reset asserted mid-packet clears the slice immediately; the partial packet is lost.
- busy = (state==LOCKED).

Test Plan:
- Single source, NUM_SRC=2: src0 sends a 4-beat packet with data 0x0..0x3, m_axis_tready=1 -> one IDLE cycle, then 4 beats on m_axis in order, 1 cycle after each accept; tlast on beat 3; pkt_cnt[0]=1.
- Round-robin: src0 and src1 each stream 3-beat packets continuously -> output packet order 0,1,0,1; grant_id alternates; no interleaving of beats within a packet; each pkt_cnt=2 after 4 packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during an 8-beat packet -> the s_axis_tready of the granted source drops the cycle after skid fills; output holds stable while stalled; all 8 beats delivered exactly once, in order.
- Mid-packet source gap: src1 deasserts tvalid for 3 cycles mid-packet while src0 requests -> grant stays on src1 until its tlast; src0 is served next.
- Reset mid-packet: assert reset during beat 2 of 5 -> m_axis_tvalid=0 and all tready=0 immediately; after release grant_id=NUM_SRC-1 and pkt_cnt=0; a new packet then flows normally.
- Counter wrap with CNT_W=4: src0 sends 17 one-beat packets -> pkt_cnt[0] reads 1 and src1's counter is unchanged.
